// File: rtl/mem_controller.sv
// Mini SRC memory initiator: owns MAR/MDR and sequences single read/write
// transactions into a synchronous RAM with a registered read port.
module mem_controller #(
    parameter int unsigned ADDR_W     = 9,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned RD_LATENCY = 1
) (
    input  logic              clk,
    input  logic              clr,
    input  logic [DATA_W-1:0] bus_in,
    input  logic              mar_in,
    input  logic              mdr_in,
    input  logic              rd_req,
    input  logic              wr_req,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [DATA_W-1:0] mdr_out,
    output logic [ADDR_W-1:0] ram_address,
    output logic              ram_read,
    output logic              ram_write,
    output logic [DATA_W-1:0] ram_data_out,
    input  logic [DATA_W-1:0] ram_data_in
);

    typedef enum logic [2:0] {
        StIdle,
        StRdIssue,
        StRdCap,
        StWrIssue,
        StDone
    } state_e;

    // Read strobe is held for cycles 0..LastCnt of the issue phase (RD_LATENCY <= 4).
    localparam logic [1:0] LastCnt = 2'(RD_LATENCY - 1);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] mar_q, mar_d;
    logic [DATA_W-1:0] mdr_q, mdr_d;
    logic [1:0]        cnt_q, cnt_d;
    logic              err_q, err_d;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q <= StIdle;
            mar_q   <= '0;
            mdr_q   <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            mar_q   <= mar_d;
            mdr_q   <= mdr_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        mar_d   = mar_q;
        mdr_d   = mdr_q;
        cnt_d   = cnt_q;
        err_d   = 1'b0;
        case (state_q)
            StIdle: begin
                if (mar_in) mar_d = bus_in[ADDR_W-1:0];
                if (mdr_in) mdr_d = bus_in;
                if (rd_req && wr_req) begin
                    err_d = 1'b1;
                end else if (rd_req) begin
                    state_d = StRdIssue;
                    cnt_d   = '0;
                end else if (wr_req) begin
                    state_d = StWrIssue;
                end
            end
            StRdIssue: begin
                if (cnt_q == LastCnt) state_d = StRdCap;
                else                  cnt_d   = cnt_q + 2'd1;
            end
            StRdCap: begin
                // RAM output is valid now; it goes undefined after this edge.
                mdr_d   = ram_data_in;
                state_d = StDone;
            end
            StWrIssue: state_d = StDone;
            StDone:    state_d = StIdle;
            default:   state_d = StIdle;
        endcase
    end

    assign busy         = (state_q != StIdle);
    assign done         = (state_q == StDone);
    assign err          = err_q;
    assign mdr_out      = mdr_q;
    assign ram_address  = mar_q;
    assign ram_data_out = mdr_q;
    assign ram_read     = (state_q == StRdIssue);
    assign ram_write    = (state_q == StWrIssue);

endmodule

// File: tb/tb_mem_controller.sv
// Directed bench for mem_controller: default build plus an RD_LATENCY=3 build,
// each attached to a behavioural 512x32 RAM with a registered read port.
module tb_mem_controller;

    logic        clk = 1'b0;
    logic        clr = 1'b1;
    logic [31:0] bus_in = '0;
    logic        mar_in = 1'b0;
    logic        mdr_in = 1'b0;
    logic        rd_req = 1'b0;
    logic        wr_req = 1'b0;
    logic        rd_req_b = 1'b0;

    logic        busy_a, done_a, err_a, ram_read_a, ram_write_a;
    logic [31:0] mdr_out_a, ram_data_out_a, rdata_a;
    logic [8:0]  ram_address_a;
    logic        busy_b, done_b, err_b, ram_read_b, ram_write_b;
    logic [31:0] mdr_out_b, ram_data_out_b, rdata_b;
    logic [8:0]  ram_address_b;

    logic [31:0] mem_a [0:511];
    logic [31:0] mem_b [0:511];
    int          wr_cnt_a = 0;
    int          overlap_a = 0;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mem_controller #(.ADDR_W(9), .DATA_W(32), .RD_LATENCY(1)) u_dut_a (
        .clk          (clk),
        .clr          (clr),
        .bus_in       (bus_in),
        .mar_in       (mar_in),
        .mdr_in       (mdr_in),
        .rd_req       (rd_req),
        .wr_req       (wr_req),
        .busy         (busy_a),
        .done         (done_a),
        .err          (err_a),
        .mdr_out      (mdr_out_a),
        .ram_address  (ram_address_a),
        .ram_read     (ram_read_a),
        .ram_write    (ram_write_a),
        .ram_data_out (ram_data_out_a),
        .ram_data_in  (rdata_a)
    );

    mem_controller #(.ADDR_W(9), .DATA_W(32), .RD_LATENCY(3)) u_dut_b (
        .clk          (clk),
        .clr          (clr),
        .bus_in       (bus_in),
        .mar_in       (mar_in),
        .mdr_in       (mdr_in),
        .rd_req       (rd_req_b),
        .wr_req       (1'b0),
        .busy         (busy_b),
        .done         (done_b),
        .err          (err_b),
        .mdr_out      (mdr_out_b),
        .ram_address  (ram_address_b),
        .ram_read     (ram_read_b),
        .ram_write    (ram_write_b),
        .ram_data_out (ram_data_out_b),
        .ram_data_in  (rdata_b)
    );

    // RAM models: output is junk unless a read strobe was sampled on the last edge.
    always @(posedge clk) begin
        if (clr) begin
            mem_a[9'h001] <= 32'h1111_1111;
            mem_a[9'h002] <= 32'h2222_2222;
            mem_a[9'h010] <= 32'h5555_AAAA;
            mem_b[9'h033] <= 32'hCAFE_F00D;
        end
        if (ram_write_a) begin
            mem_a[ram_address_a] <= ram_data_out_a;
            wr_cnt_a <= wr_cnt_a + 1;
        end
        if (ram_read_a && ram_write_a) overlap_a <= overlap_a + 1;
        rdata_a <= ram_read_a ? mem_a[ram_address_a] : 32'hBAD0_BAD0;
        if (ram_write_b) mem_b[ram_address_b] <= ram_data_out_b;
        rdata_b <= ram_read_b ? mem_b[ram_address_b] : 32'hBAD0_BAD0;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_mar(input logic [31:0] v);
        bus_in = v; mar_in = 1'b1;
        tick();
        mar_in = 1'b0;
    endtask

    task automatic load_mdr(input logic [31:0] v);
        bus_in = v; mdr_in = 1'b1;
        tick();
        mdr_in = 1'b0;
    endtask

    task automatic read_a(input string tag, input logic [31:0] exp);
        rd_req = 1'b1;
        tick();
        rd_req = 1'b0;
        check({tag, "_c1_rd"}, ram_read_a, 1);
        check({tag, "_c1_busy"}, busy_a, 1);
        tick();
        check({tag, "_c2_rd"}, ram_read_a, 0);
        check({tag, "_c2_done"}, done_a, 0);
        tick();
        check({tag, "_c3_done"}, done_a, 1);
        check({tag, "_c3_mdr"}, mdr_out_a, exp);
        tick();
        check({tag, "_idle_busy"}, busy_a, 0);
        check({tag, "_idle_done"}, done_a, 0);
    endtask

    initial begin
        tick();
        tick();
        check("rst_busy", busy_a, 0);
        check("rst_done", done_a, 0);
        check("rst_err", err_a, 0);
        check("rst_rd", ram_read_a, 0);
        check("rst_wr", ram_write_a, 0);
        check("rst_mdr", mdr_out_a, 0);
        check("rst_mar", ram_address_a, 0);
        clr = 1'b0;
        tick();

        // 1: asynchronous reset in the middle of a read
        load_mar(32'h0000_0010);
        load_mdr(32'h0BAD_F00D);
        rd_req = 1'b1;
        tick();
        rd_req = 1'b0;
        check("t1_rd_issue", ram_read_a, 1);
        #2 clr = 1'b1;
        #1;
        check("t1_async_rd", ram_read_a, 0);
        check("t1_async_busy", busy_a, 0);
        check("t1_async_mdr", mdr_out_a, 0);
        check("t1_async_mar", ram_address_a, 0);
        tick();
        check("t1_no_done", done_a, 0);
        clr = 1'b0;
        tick();
        check("t1_idle_done", done_a, 0);
        check("t1_idle_busy", busy_a, 0);

        // 2: write then read back
        load_mar(32'h0000_00A5);
        load_mdr(32'hDEAD_BEEF);
        wr_req = 1'b1;
        tick();
        wr_req = 1'b0;
        check("t2_c1_wr", ram_write_a, 1);
        check("t2_c1_rd", ram_read_a, 0);
        check("t2_c1_addr", ram_address_a, 9'h0A5);
        check("t2_c1_data", ram_data_out_a, 32'hDEAD_BEEF);
        check("t2_c1_done", done_a, 0);
        tick();
        check("t2_c2_wr", ram_write_a, 0);
        check("t2_c2_done", done_a, 1);
        tick();
        check("t2_idle_done", done_a, 0);
        check("t2_mem", mem_a[9'h0A5], 32'hDEAD_BEEF);
        load_mdr(32'h0);
        check("t2_mdr_clr", mdr_out_a, 0);
        read_a("t2_rd", 32'hDEAD_BEEF);

        // 3: address truncation; MDR load and write request in the same cycle
        load_mar(32'h0000_03FF);
        check("t3_mar_trunc", ram_address_a, 9'h1FF);
        bus_in = 32'h1234_5678; mdr_in = 1'b1; wr_req = 1'b1;
        tick();
        mdr_in = 1'b0; wr_req = 1'b0;
        check("t3_c1_wr", ram_write_a, 1);
        check("t3_c1_data", ram_data_out_a, 32'h1234_5678);
        tick();
        check("t3_c2_done", done_a, 1);
        tick();
        load_mdr(32'h0);
        read_a("t3_rd", 32'h1234_5678);
        load_mar(32'h0000_0200);
        check("t3_mar_wrap", ram_address_a, 9'h000);

        // 4: simultaneous requests
        rd_req = 1'b1; wr_req = 1'b1;
        tick();
        rd_req = 1'b0; wr_req = 1'b0;
        check("t4_err", err_a, 1);
        check("t4_busy", busy_a, 0);
        check("t4_rd", ram_read_a, 0);
        check("t4_wr", ram_write_a, 0);
        check("t4_mar", ram_address_a, 9'h000);
        check("t4_mdr", mdr_out_a, 32'h1234_5678);
        tick();
        check("t4_err_off", err_a, 0);
        check("t4_busy2", busy_a, 0);

        // 5: loads and requests ignored while busy
        load_mar(32'h0000_0001);
        rd_req = 1'b1;
        tick();
        rd_req = 1'b0;
        check("t5_c1_rd", ram_read_a, 1);
        bus_in = 32'h0000_0002; mar_in = 1'b1; wr_req = 1'b1;
        tick();
        mar_in = 1'b0; wr_req = 1'b0;
        check("t5_c2_mar", ram_address_a, 9'h001);
        check("t5_c2_wr", ram_write_a, 0);
        tick();
        check("t5_c3_done", done_a, 1);
        check("t5_c3_mdr", mdr_out_a, 32'h1111_1111);
        check("t5_c3_mar", ram_address_a, 9'h001);
        check("t5_c3_wr", ram_write_a, 0);
        tick();
        check("t5_idle_wr", ram_write_a, 0);
        check("t5_mem2", mem_a[9'h002], 32'h2222_2222);

        // 6: RD_LATENCY=3 build
        load_mar(32'h0000_0033);
        rd_req_b = 1'b1;
        tick();
        rd_req_b = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            check($sformatf("t6_c%0d_rd", c), ram_read_b, 1);
            check($sformatf("t6_c%0d_done", c), done_b, 0);
            tick();
        end
        check("t6_c4_rd", ram_read_b, 0);
        check("t6_c4_done", done_b, 0);
        check("t6_c4_busy", busy_b, 1);
        tick();
        check("t6_c5_done", done_b, 1);
        check("t6_c5_mdr", mdr_out_b, 32'hCAFE_F00D);
        tick();
        check("t6_idle_busy", busy_b, 0);
        check("t6_idle_done", done_b, 0);

        check("wr_count", wr_cnt_a, 2);
        check("rd_wr_overlap", overlap_a, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
